// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round controller: state encoding,
// player count limit and saturating score arithmetic.
package quiz_pkg;

  localparam int N_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    OPEN   = 2'd2,
    ANSWER = 2'd3
  } state_e;

  // Adds or subtracts a 6-bit point value, clamped to a w-bit signed range (w <= 31).
  function automatic logic signed [31:0] sat_update(input logic signed [31:0] score,
                                                    input logic [5:0]         pts,
                                                    input logic               sub,
                                                    input int                 w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = sub ? (score - $signed({26'd0, pts})) : (score + $signed({26'd0, pts}));
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: pulses tick for one cycle every CLK_HZ cycles,
// held at zero while clr is high.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == CW'(CLK_HZ - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: buzz-in arbitration, answer countdown, host
// judgement and early-press foul scoring for up to four players.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [5:0]               num_people,
  input  logic [5:0]               count_seconds,
  input  logic [5:0]               correct_point,
  input  logic [5:0]               mistake_point,
  input  logic                     start_btn,
  input  logic                     judge_ok,
  input  logic                     judge_ng,
  input  logic [3:0]               player_btn,
  output logic [1:0]               state,
  output logic [1:0]               winner,
  output logic                     winner_valid,
  output logic [5:0]               seconds_left,
  output logic [4*SCORE_W-1:0]     scores,
  output logic                     foul_pulse,
  output logic [1:0]               foul_player,
  output logic                     timeout_pulse
);

  state_e                    state_q;
  logic [3:0]                btn_q;
  logic [5:0]                cfg_people;
  logic [5:0]                cfg_secs;
  logic [5:0]                cfg_correct;
  logic [5:0]                cfg_mistake;
  logic signed [SCORE_W-1:0] score_r [N_MAX];
  logic [3:0]                en_mask;
  logic [3:0]                rise;
  logic [1:0]                rise_idx;
  logic                      sec_tick;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ANSWER),
    .tick  (sec_tick)
  );

  // Lowest-index rising button wins both the answer slot and the foul penalty.
  always_comb begin
    for (int i = 0; i < N_MAX; i++) en_mask[i] = (6'(i) < cfg_people);
    rise     = player_btn & ~btn_q & en_mask;
    rise_idx = '0;
    for (int i = N_MAX - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = 2'(i);
    end
  end

  assign state = state_q;

  for (genvar g = 0; g < N_MAX; g++) begin : g_pack
    assign scores[g*SCORE_W +: SCORE_W] = score_r[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      winner        <= '0;
      winner_valid  <= 1'b0;
      seconds_left  <= '0;
      foul_pulse    <= 1'b0;
      foul_player   <= '0;
      timeout_pulse <= 1'b0;
      btn_q         <= '0;
      cfg_people    <= '0;
      cfg_secs      <= '0;
      cfg_correct   <= '0;
      cfg_mistake   <= '0;
      for (int i = 0; i < N_MAX; i++) score_r[i] <= '0;
    end else begin
      btn_q         <= player_btn;
      foul_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      if (!cfg_valid) begin
        state_q      <= IDLE;
        winner_valid <= 1'b0;
        seconds_left <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cfg_people  <= num_people;
            cfg_secs    <= count_seconds;
            cfg_correct <= correct_point;
            cfg_mistake <= mistake_point;
            for (int i = 0; i < N_MAX; i++) score_r[i] <= '0;
            state_q <= READY;
          end
          READY: begin
            if (rise != 4'd0) begin
              score_r[rise_idx] <= SCORE_W'(sat_update(32'(score_r[rise_idx]), cfg_mistake,
                                                       1'b1, SCORE_W));
              foul_pulse  <= 1'b1;
              foul_player <= rise_idx;
            end
            if (start_btn) state_q <= OPEN;
          end
          OPEN: begin
            if (rise != 4'd0) begin
              state_q      <= ANSWER;
              winner       <= rise_idx;
              winner_valid <= 1'b1;
              seconds_left <= cfg_secs;
            end
          end
          ANSWER: begin
            // Judgement beats an expiring tick; both judges at once is ignored.
            if (judge_ok && !judge_ng) begin
              score_r[winner] <= SCORE_W'(sat_update(32'(score_r[winner]), cfg_correct,
                                                     1'b0, SCORE_W));
              state_q      <= READY;
              winner_valid <= 1'b0;
              seconds_left <= '0;
            end else if (judge_ng && !judge_ok) begin
              score_r[winner] <= SCORE_W'(sat_update(32'(score_r[winner]), cfg_mistake,
                                                     1'b1, SCORE_W));
              state_q      <= READY;
              winner_valid <= 1'b0;
              seconds_left <= '0;
            end else if (sec_tick) begin
              if (seconds_left <= 6'd1 && !judge_ok && !judge_ng) begin
                score_r[winner] <= SCORE_W'(sat_update(32'(score_r[winner]), cfg_mistake,
                                                       1'b1, SCORE_W));
                timeout_pulse <= 1'b1;
                state_q       <= READY;
                winner_valid  <= 1'b0;
                seconds_left  <= '0;
              end else if (seconds_left > 6'd1) begin
                seconds_left <= seconds_left - 6'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed self-checking bench for quiz_round_ctrl with a fast prescaler
// (CLK_HZ=10) and 8-bit scores.
module tb_quiz_round_ctrl;

  localparam int SCORE_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid;
  logic [5:0]           num_people;
  logic [5:0]           count_seconds;
  logic [5:0]           correct_point;
  logic [5:0]           mistake_point;
  logic                 start_btn;
  logic                 judge_ok;
  logic                 judge_ng;
  logic [3:0]           player_btn;
  logic [1:0]           state;
  logic [1:0]           winner;
  logic                 winner_valid;
  logic [5:0]           seconds_left;
  logic [4*SCORE_W-1:0] scores;
  logic                 foul_pulse;
  logic [1:0]           foul_player;
  logic                 timeout_pulse;

  int total = 0;
  int bad   = 0;

  quiz_round_ctrl #(.CLK_HZ(10), .SCORE_W(SCORE_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .num_people    (num_people),
    .count_seconds (count_seconds),
    .correct_point (correct_point),
    .mistake_point (mistake_point),
    .start_btn     (start_btn),
    .judge_ok      (judge_ok),
    .judge_ng      (judge_ng),
    .player_btn    (player_btn),
    .state         (state),
    .winner        (winner),
    .winner_valid  (winner_valid),
    .seconds_left  (seconds_left),
    .scores        (scores),
    .foul_pulse    (foul_pulse),
    .foul_player   (foul_player),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_score(input string tag, input int idx, input int exp);
    logic [7:0] exp8;
    exp8 = 8'(exp);
    check_output(tag, {24'd0, scores[idx*SCORE_W +: SCORE_W]}, {24'd0, exp8});
  endtask

  initial begin
    int neg_exp [3] = '{-63, -126, -128};
    rst_n = 1'b0; cfg_valid = 1'b0; num_people = 6'd0; count_seconds = 6'd0;
    correct_point = 6'd0; mistake_point = 6'd0; start_btn = 1'b0;
    judge_ok = 1'b0; judge_ng = 1'b0; player_btn = 4'd0;
    cyc(); cyc();
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_wv", 32'(winner_valid), 32'd0);
    check_output("rst_scores", scores, 32'd0);
    check_output("rst_secs", 32'(seconds_left), 32'd0);
    rst_n = 1'b1;
    cyc();

    $display("[TB] config and fouls");
    cfg_valid = 1'b1; num_people = 6'd3; count_seconds = 6'd2;
    correct_point = 6'd5; mistake_point = 6'd3;
    cyc();
    check_output("cfg_ready", 32'(state), 32'd1);
    player_btn = 4'b0100; cyc();
    check_output("foul_state", 32'(state), 32'd1);
    check_output("foul_pulse", 32'(foul_pulse), 32'd1);
    check_output("foul_player", 32'(foul_player), 32'd2);
    check_score("foul_score2", 2, -3);
    player_btn = 4'd0; cyc();
    check_output("foul_pulse_len", 32'(foul_pulse), 32'd0);
    player_btn = 4'b0100; start_btn = 1'b1; cyc();
    check_output("foul_start_state", 32'(state), 32'd2);
    check_output("foul_start_pulse", 32'(foul_pulse), 32'd1);
    check_score("foul_start_score2", 2, -6);
    player_btn = 4'd0; start_btn = 1'b0; cyc();

    $display("[TB] arbitration");
    player_btn = 4'b1000; cyc();
    check_output("masked_p3", 32'(state), 32'd2);
    player_btn = 4'd0; cyc();
    player_btn = 4'b1110; cyc();
    check_output("arb_state", 32'(state), 32'd3);
    check_output("arb_winner", 32'(winner), 32'd1);
    check_output("arb_wv", 32'(winner_valid), 32'd1);
    check_output("arb_secs", 32'(seconds_left), 32'd2);
    judge_ok = 1'b1; judge_ng = 1'b1; cyc();
    check_output("both_state", 32'(state), 32'd3);
    check_score("both_score1", 1, 0);
    judge_ng = 1'b0; player_btn = 4'd0; cyc();
    judge_ok = 1'b0;
    check_output("ok_state", 32'(state), 32'd1);
    check_score("ok_score1", 1, 5);
    check_output("ok_wv", 32'(winner_valid), 32'd0);
    check_output("ok_secs", 32'(seconds_left), 32'd0);

    $display("[TB] countdown timeout");
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; player_btn = 4'b0001; cyc();
    check_output("to_entry", 32'(state), 32'd3);
    player_btn = 4'd0;
    repeat (9) cyc();
    check_output("to_secs_9", 32'(seconds_left), 32'd2);
    cyc();
    check_output("to_secs_10", 32'(seconds_left), 32'd1);
    repeat (9) cyc();
    check_output("to_early", 32'(timeout_pulse), 32'd0);
    cyc();
    check_output("to_pulse", 32'(timeout_pulse), 32'd1);
    check_output("to_state", 32'(state), 32'd1);
    check_score("to_score0", 0, -3);
    check_output("to_secs", 32'(seconds_left), 32'd0);
    cyc();
    check_output("to_pulse_len", 32'(timeout_pulse), 32'd0);

    $display("[TB] judge on final tick");
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; player_btn = 4'b0001; cyc();
    player_btn = 4'd0;
    repeat (19) cyc();
    judge_ok = 1'b1; cyc();
    judge_ok = 1'b0;
    check_output("jt_no_timeout", 32'(timeout_pulse), 32'd0);
    check_output("jt_state", 32'(state), 32'd1);
    check_score("jt_score0", 0, 2);

    $display("[TB] positive saturation");
    for (int i = 0; i < 30; i++) begin
      start_btn = 1'b1; cyc();
      start_btn = 1'b0; player_btn = 4'b0001; cyc();
      player_btn = 4'd0; judge_ok = 1'b1; cyc();
      judge_ok = 1'b0;
    end
    check_score("sat_pos", 0, 127);

    $display("[TB] abort and reconfig");
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; player_btn = 4'b0001; cyc();
    check_output("abort_entry", 32'(state), 32'd3);
    player_btn = 4'd0; cfg_valid = 1'b0; cyc();
    check_output("abort_state", 32'(state), 32'd0);
    check_output("abort_wv", 32'(winner_valid), 32'd0);
    check_score("abort_score0", 0, 127);
    mistake_point = 6'd63; cfg_valid = 1'b1; cyc();
    check_output("recfg_state", 32'(state), 32'd1);
    check_score("recfg_clear", 0, 0);
    for (int i = 0; i < 3; i++) begin
      player_btn = 4'b0010; cyc();
      check_score("sat_neg", 1, neg_exp[i]);
      player_btn = 4'd0; cyc();
    end
    check_output("neg_foul_player", 32'(foul_player), 32'd1);

    $display("[TB] async reset mid-answer");
    start_btn = 1'b1; cyc();
    start_btn = 1'b0; player_btn = 4'b0100; cyc();
    check_output("rst2_entry", 32'(winner), 32'd2);
    rst_n = 1'b0;
    #2;
    check_output("rst2_state", 32'(state), 32'd0);
    check_output("rst2_wv", 32'(winner_valid), 32'd0);
    check_output("rst2_winner", 32'(winner), 32'd0);
    check_output("rst2_scores", scores, 32'd0);
    check_output("rst2_foul_player", 32'(foul_player), 32'd0);
    check_output("rst2_secs", 32'(seconds_left), 32'd0);
    player_btn = 4'd0;
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
